// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: scans NUM_DIGITS digits over a
// shared active-low segment bus, with a blanking gap before each digit.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DRIVE_CYC  = 100000,
    parameter int unsigned BLANK_CYC  = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int unsigned CMAX = (DRIVE_CYC > BLANK_CYC) ? DRIVE_CYC : BLANK_CYC;
    localparam int unsigned CW   = ($clog2(CMAX) < 1) ? 1 : $clog2(CMAX);
    localparam int unsigned IW   = $clog2(NUM_DIGITS);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t                  state, state_nx;
    logic [CW-1:0]           cnt, cnt_nx;
    logic [IW-1:0]           idx, idx_nx;
    logic                    boundary;

    logic [4*NUM_DIGITS-1:0] stg_value, stg_value_nx;
    logic [NUM_DIGITS-1:0]   stg_dp, stg_dp_nx;
    logic [NUM_DIGITS-1:0]   stg_en, stg_en_nx;
    logic                    pending, pending_nx;

    logic [4*NUM_DIGITS-1:0] sh_value, sh_value_nx;
    logic [NUM_DIGITS-1:0]   sh_dp, sh_dp_nx;
    logic [NUM_DIGITS-1:0]   sh_en, sh_en_nx;

    logic [NUM_DIGITS-1:0]   an_nx;
    logic [6:0]              seg_nx;
    logic                    dp_n_nx;
    logic [3:0]              nibble;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CW'(1);
        idx_nx   = idx;
        boundary = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == CW'(BLANK_CYC - 1)) begin
                    state_nx = DRIVE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                if (cnt == CW'(DRIVE_CYC - 1)) begin
                    state_nx = BLANK;
                    cnt_nx   = '0;
                    if (idx == IW'(NUM_DIGITS - 1)) begin
                        idx_nx   = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_nx = idx + IW'(1);
                    end
                end
            end
        endcase

        stg_value_nx = load ? value    : stg_value;
        stg_dp_nx    = load ? dp       : stg_dp;
        stg_en_nx    = load ? digit_en : stg_en;

        // A load coinciding with the frame boundary bypasses staging straight into
        // the shadow, so nothing is left pending.
        sh_value_nx = sh_value;
        sh_dp_nx    = sh_dp;
        sh_en_nx    = sh_en;
        pending_nx  = pending;
        if (boundary) begin
            pending_nx = 1'b0;
            if (load) begin
                sh_value_nx = value;
                sh_dp_nx    = dp;
                sh_en_nx    = digit_en;
            end else if (pending) begin
                sh_value_nx = stg_value;
                sh_dp_nx    = stg_dp;
                sh_en_nx    = stg_en;
            end
        end else if (load) begin
            pending_nx = 1'b1;
        end

        nibble  = sh_value_nx[{idx_nx, 2'b00} +: 4];
        an_nx   = '1;
        seg_nx  = 7'h7F;
        dp_n_nx = 1'b1;
        if (state_nx == DRIVE && sh_en_nx[idx_nx]) begin
            an_nx[idx_nx] = 1'b0;
            seg_nx        = hex7(nibble);
            dp_n_nx       = ~sh_dp_nx[idx_nx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            stg_value  <= '0;
            stg_dp     <= '0;
            stg_en     <= '0;
            pending    <= 1'b0;
            sh_value   <= '0;
            sh_dp      <= '0;
            sh_en      <= '0;
            an         <= '1;
            seg        <= 7'h7F;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            stg_value  <= stg_value_nx;
            stg_dp     <= stg_dp_nx;
            stg_en     <= stg_en_nx;
            pending    <= pending_nx;
            sh_value   <= sh_value_nx;
            sh_dp      <= sh_dp_nx;
            sh_en      <= sh_en_nx;
            an         <= an_nx;
            seg        <= seg_nx;
            dp_n       <= dp_n_nx;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a frame-position model predicts every
// output cycle; predictions are queued at the clock edge and compared half a cycle later.
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int BC    = 2;
    localparam int DC    = 4;
    localparam int SLOT  = BC + DC;
    localparam int FRAME = ND * SLOT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   value = '0;
    logic [3:0]    dp = '0;
    logic [3:0]    digit_en = '0;
    logic          load = 1'b0;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp_n;
    logic          frame_done;

    seg7_scan_driver #(.NUM_DIGITS(ND), .DRIVE_CYC(DC), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .digit_en(digit_en),
        .load(load), .an(an), .seg(seg), .dp_n(dp_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp_n;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [6:0] dec_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model state: edges since reset release, plus staging/shadow copies.
    int          m = 0;
    logic [15:0] m_stg_v, m_sh_v;
    logic [3:0]  m_stg_dp, m_sh_dp, m_stg_en, m_sh_en;
    logic        m_pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        int   f, slot, w;
        logic bnd;
        if (!rst_n) begin
            m = 0;
            m_stg_v = '0; m_stg_dp = '0; m_stg_en = '0;
            m_sh_v  = '0; m_sh_dp  = '0; m_sh_en  = '0;
            m_pend  = 1'b0;
        end else begin
            m++;
            bnd = (m % FRAME == 0);
            if (bnd) begin
                if (load) begin
                    m_sh_v = value; m_sh_dp = dp; m_sh_en = digit_en;
                end else if (m_pend) begin
                    m_sh_v = m_stg_v; m_sh_dp = m_stg_dp; m_sh_en = m_stg_en;
                end
                m_pend = 1'b0;
            end else if (load) begin
                m_pend = 1'b1;
            end
            if (load) begin
                m_stg_v = value; m_stg_dp = dp; m_stg_en = digit_en;
            end
            f    = m % FRAME;
            slot = f / SLOT;
            w    = f % SLOT;
            e.an   = 4'b1111;
            e.seg  = 7'h7F;
            e.dp_n = 1'b1;
            e.fd   = bnd;
            if (w >= BC && m_sh_en[slot]) begin
                e.an[slot] = 1'b0;
                e.seg      = dec_tab[(m_sh_v >> (4 * slot)) & 16'hF];
                e.dp_n     = ~m_sh_dp[slot];
            end
            sb.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && sb.size() > 0) begin
            e = sb.pop_front();
            check("out{an,seg,dp_n,fd}", {19'd0, an, seg, dp_n, frame_done},
                  {19'd0, e.an, e.seg, e.dp_n, e.fd});
            check("an_at_most_one_low", {31'd0, ($countones(~an) <= 1)}, 32'd1);
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] en);
        value = v; dp = d; digit_en = en; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_phase(input int ph, input string tag);
        int budget = 4 * FRAME;
        while ((m % FRAME) != ph && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_an",  {28'd0, an}, 32'hF);
        check("reset_seg", {25'd0, seg}, 32'h7F);
        check("reset_dpn", {31'd0, dp_n}, 32'd1);
        check("reset_fd",  {31'd0, frame_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: dark display, frame_done every frame
        repeat (2 * FRAME) @(negedge clk);

        // 3A0F with dp on digit 2
        do_load(16'h3A0F, 4'b0100, 4'hF);
        repeat (2 * FRAME + 5) @(negedge clk);

        // Mid-frame reload; current frame must finish with old value
        wait_phase(9, "midframe");
        do_load(16'h1234, 4'b0000, 4'hF);
        repeat (2 * FRAME) @(negedge clk);

        // Load sampled on the frame-boundary edge itself
        wait_phase(FRAME - 1, "boundary");
        do_load(16'h8888, 4'b0000, 4'hF);
        repeat (FRAME + 3) @(negedge clk);
        check("bypass_digit0", {25'd0, seg}, {25'd0, (an == 4'b1111) ? 7'h7F : 7'b0000000});

        // Digits 1 and 3 disabled
        do_load(16'hBCDE, 4'b1111, 4'b0101);
        repeat (3 * FRAME) @(negedge clk);

        // Async reset during DRIVE of digit 2
        wait_phase(14, "drive2");
        @(posedge clk);
        #1;
        check("pre_reset_an", {28'd0, an}, 32'hB);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midreset_an",  {28'd0, an}, 32'hF);
        check("midreset_seg", {25'd0, seg}, 32'h7F);
        check("midreset_dpn", {31'd0, dp_n}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * FRAME) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
